div_ctrl: RTL and testbench



---
 rtl/div_ctrl_if.sv | 26 ++
 rtl/div_ctrl.sv | 153 +++++++++++++++
 tb/tb_div_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// Handshake and operand bundle between the ex stage and the divide sequencer.
// master = ex-stage requester, slave = div_ctrl.
interface div_ctrl_if #(
    parameter int DATA_W = 32
);
    logic              start_i;
    logic              annul_i;
    logic              signed_i;
    logic              rem_i;
    logic [DATA_W-1:0] op1_i;
    logic [DATA_W-1:0] op2_i;
    logic [DATA_W-1:0] result_o;
    logic              ready_o;
    logic              stall_req_o;
    logic              busy_o;

    modport master (
        output start_i, annul_i, signed_i, rem_i, op1_i, op2_i,
        input  result_o, ready_o, stall_req_o, busy_o
    );

    modport slave (
        input  start_i, annul_i, signed_i, rem_i, op1_i, op2_i,
        output result_o, ready_o, stall_req_o, busy_o
    );
endinterface

// File: rtl/div_ctrl.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring divide plus single-cycle
// divide-by-zero and signed-overflow paths; holds the pipeline until ready_o.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic        clk,
    input  logic        rst,
    div_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [DATA_W-1:0] MIN_NEG  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic [DATA_W-1:0] ALL_ONES = {DATA_W{1'b1}};

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d;
    logic [DATA_W-1:0] quo_q, quo_d;
    logic [DATA_W-1:0] dvs_q, dvs_d;
    logic [DATA_W-1:0] result_q, result_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic              rem_sel_q, rem_sel_d;
    logic              ready_q, ready_d;

    logic              op1_neg, op2_neg;
    logic [DATA_W-1:0] op1_mag, op2_mag;
    logic [DATA_W:0]   trial_rem, trial_diff;
    logic [DATA_W-1:0] quo_fix, rem_fix;

    assign op1_neg    = bus.signed_i & bus.op1_i[DATA_W-1];
    assign op2_neg    = bus.signed_i & bus.op2_i[DATA_W-1];
    assign op1_mag    = op1_neg ? -bus.op1_i : bus.op1_i;
    assign op2_mag    = op2_neg ? -bus.op2_i : bus.op2_i;

    // The dividend register doubles as the quotient: its MSB shifts into the
    // partial remainder while the new quotient bit enters at the LSB.
    assign trial_rem  = {rem_q, quo_q[DATA_W-1]};
    assign trial_diff = trial_rem - {1'b0, dvs_q};

    assign quo_fix    = neg_quo_q ? -quo_q : quo_q;
    assign rem_fix    = neg_rem_q ? -rem_q : rem_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        result_d  = result_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        rem_sel_d = rem_sel_q;
        ready_d   = ready_q;

        case (state_q)
            IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (bus.start_i && !bus.annul_i) begin
                    rem_sel_d = bus.rem_i;
                    if (bus.op2_i == '0) begin
                        quo_d     = ALL_ONES;
                        rem_d     = bus.op1_i;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DONE;
                    end else if (bus.signed_i && bus.op1_i == MIN_NEG && bus.op2_i == ALL_ONES) begin
                        quo_d     = MIN_NEG;
                        rem_d     = '0;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                        state_d   = DONE;
                    end else begin
                        quo_d     = op1_mag;
                        dvs_d     = op2_mag;
                        rem_d     = '0;
                        cnt_d     = '0;
                        neg_quo_d = op1_neg ^ op2_neg;
                        neg_rem_d = op1_neg;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                if (!trial_diff[DATA_W]) begin
                    rem_d = trial_diff[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b1};
                end else begin
                    rem_d = trial_rem[DATA_W-1:0];
                    quo_d = {quo_q[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.start_i) begin
                    ready_d  = 1'b1;
                    result_d = rem_sel_q ? rem_fix : quo_fix;
                end else begin
                    ready_d  = 1'b0;
                    result_d = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Flush wins over everything, including a start in the same cycle.
        if (bus.annul_i) begin
            state_d  = IDLE;
            ready_d  = 1'b0;
            result_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            result_q  <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            rem_sel_q <= 1'b0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            result_q  <= result_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            rem_sel_q <= rem_sel_d;
            ready_q   <= ready_d;
        end
    end

    assign bus.result_o    = result_q;
    assign bus.ready_o     = ready_q;
    assign bus.busy_o      = (state_q != IDLE);
    assign bus.stall_req_o = bus.start_i & ~ready_q & ~bus.annul_i & ~rst;
endmodule

// File: tb/tb_div_ctrl.sv
// Self-checking bench for div_ctrl against an arithmetic RV32M divide model.
module tb_div_ctrl;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    div_ctrl_if #(.DATA_W(32)) bus ();

    div_ctrl #(.DATA_W(32), .CNT_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        s;
        logic        r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
    } vec_t;

    function automatic logic [31:0] model_div(input logic s, input logic r,
                                              input logic [31:0] a, input logic [31:0] b);
        logic [31:0]        q, m;
        logic signed [31:0] sa, sb;
        sa = a;
        sb = b;
        if (b == 32'd0) begin
            q = 32'hFFFF_FFFF;
            m = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            m = 32'd0;
        end else if (s) begin
            q = sa / sb;
            m = sa % sb;
        end else begin
            q = a / b;
            m = a % b;
        end
        return r ? m : q;
    endfunction

    function automatic int model_lat(input logic s, input logic [31:0] a, input logic [31:0] b);
        if (b == 32'd0 || (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
        return 33;
    endfunction

    // Launches one divide and waits (bounded) for ready_o; start stays high.
    task automatic run_div(input logic s, input logic r, input logic [31:0] a,
                           input logic [31:0] b, input int chg,
                           output logic [31:0] got, output int lat, output int stalls);
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.signed_i = s;
        bus.rem_i    = r;
        bus.op1_i    = a;
        bus.op2_i    = b;
        @(posedge clk);
        lat    = 0;
        stalls = 0;
        got    = 32'd0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (bus.stall_req_o) stalls++;
            if (n == chg) begin
                bus.op1_i    = $urandom;
                bus.op2_i    = $urandom;
                bus.signed_i = ~s;
                bus.rem_i    = ~r;
            end
            @(posedge clk);
            #1;
            if (bus.ready_o) begin
                lat = n;
                got = bus.result_o;
                break;
            end
        end
    endtask

    task automatic end_div();
        @(negedge clk);
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.start_i  = 1'b1;
        bus.annul_i  = 1'b0;
        bus.signed_i = 1'b0;
        bus.rem_i    = 1'b0;
        bus.op1_i    = 32'd5;
        bus.op2_i    = 32'd1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (bus.ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b expected 0", bus.ready_o); end
        checks++;
        if (bus.result_o !== 32'd0) begin failures++; $display("FAIL reset_result: got %h expected 0", bus.result_o); end
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", bus.busy_o); end
        checks++;
        if (bus.stall_req_o !== 1'b0) begin failures++; $display("FAIL reset_stall: got %b expected 0", bus.stall_req_o); end
        @(negedge clk);
        bus.start_i = 1'b0;
        rst         = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b0) begin failures++; $display("FAIL reset_idle: busy %b expected 0", bus.busy_o); end
    endtask

    task automatic test_directed();
        vec_t        v [10];
        logic [31:0] got;
        int          lat, stalls;
        v[0] = '{1'b0, 1'b0, 32'd100,         32'd7,         32'd14,         33};
        v[1] = '{1'b0, 1'b1, 32'd100,         32'd7,         32'd2,          33};
        v[2] = '{1'b1, 1'b0, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD,  33};
        v[3] = '{1'b1, 1'b1, 32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF,  33};
        v[4] = '{1'b1, 1'b1, 32'd7,           32'hFFFF_FFFE, 32'd1,          33};
        v[5] = '{1'b1, 1'b0, 32'h0000_1234,   32'd0,         32'hFFFF_FFFF,  1};
        v[6] = '{1'b0, 1'b1, 32'h0000_1234,   32'd0,         32'h0000_1234,  1};
        v[7] = '{1'b1, 1'b0, 32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000,  1};
        v[8] = '{1'b1, 1'b1, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,          1};
        v[9] = '{1'b0, 1'b0, 32'h8000_0000,   32'hFFFF_FFFF, 32'd0,          33};
        for (int i = 0; i < 10; i++) begin
            run_div(v[i].s, v[i].r, v[i].a, v[i].b, 0, got, lat, stalls);
            checks++;
            if (got !== v[i].exp) begin failures++; $display("FAIL dir%0d_result: got %h expected %h", i, got, v[i].exp); end
            checks++;
            if (lat !== v[i].lat) begin failures++; $display("FAIL dir%0d_latency: got %0d expected %0d", i, lat, v[i].lat); end
            checks++;
            if (stalls !== v[i].lat) begin failures++; $display("FAIL dir%0d_stall_cycles: got %0d expected %0d", i, stalls, v[i].lat); end
            end_div();
        end
    endtask

    task automatic test_random();
        logic [31:0] a, b, got;
        logic        s, r;
        int          lat, stalls, k;
        for (int i = 0; i < 24; i++) begin
            s = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            k = $urandom_range(0, 5);
            a = $urandom;
            b = $urandom;
            if (k == 0) b = 32'd0;
            else if (k == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (k == 2) begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
            else if (k == 3) b = $urandom_range(1, 255);
            run_div(s, r, a, b, 0, got, lat, stalls);
            checks++;
            if (got !== model_div(s, r, a, b)) begin
                failures++;
                $display("FAIL rand%0d_result: s=%b r=%b %h/%h got %h expected %h", i, s, r, a, b, got, model_div(s, r, a, b));
            end
            checks++;
            if (lat !== model_lat(s, a, b)) begin
                failures++;
                $display("FAIL rand%0d_latency: got %0d expected %0d", i, lat, model_lat(s, a, b));
            end
            end_div();
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got, a, b;
        int          lat, stalls;
        a = $urandom;
        b = $urandom_range(1, 5000);
        run_div(1'b0, 1'b0, a, b, 0, got, lat, stalls);
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            bus.op1_i    = $urandom;
            bus.rem_i    = 1'b1;
            @(posedge clk);
            #1;
            checks++;
            if (bus.ready_o !== 1'b1 || bus.result_o !== a / b) begin
                failures++;
                $display("FAIL hold_done%0d: ready %b result %h expected ready 1 result %h", n, bus.ready_o, bus.result_o, a / b);
            end
        end
        end_div();
        checks++;
        if (bus.ready_o !== 1'b0 || bus.result_o !== 32'd0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL release_idle: ready %b result %h busy %b expected 0 0 0", bus.ready_o, bus.result_o, bus.busy_o);
        end
        run_div(1'b1, 1'b1, a, b, 0, got, lat, stalls);
        checks++;
        if (got !== model_div(1'b1, 1'b1, a, b) || lat !== 33) begin
            failures++;
            $display("FAIL back_to_back: got %h lat %0d expected %h lat 33", got, lat, model_div(1'b1, 1'b1, a, b));
        end
        end_div();
    endtask

    task automatic test_annul();
        logic [31:0] got;
        int          lat, stalls;
        @(negedge clk);
        bus.start_i  = 1'b1;
        bus.signed_i = 1'b0;
        bus.rem_i    = 1'b0;
        bus.op1_i    = 32'hFFFF_0000;
        bus.op2_i    = 32'd3;
        @(posedge clk);
        repeat (9) @(posedge clk);
        @(negedge clk);
        bus.annul_i = 1'b1;
        #1;
        checks++;
        if (bus.stall_req_o !== 1'b0) begin failures++; $display("FAIL annul_stall: got %b expected 0", bus.stall_req_o); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0) begin
            failures++;
            $display("FAIL annul_idle: busy %b ready %b expected 0 0", bus.busy_o, bus.ready_o);
        end
        @(negedge clk);
        bus.annul_i = 1'b0;
        bus.start_i = 1'b0;
        run_div(1'b0, 1'b0, 32'd9, 32'd3, 0, got, lat, stalls);
        checks++;
        if (got !== 32'd3 || lat !== 33) begin
            failures++;
            $display("FAIL after_annul: got %h lat %0d expected 3 lat 33", got, lat);
        end
        end_div();
    endtask

    task automatic test_rst_mid();
        logic [31:0] got;
        int          lat, stalls;
        run_div(1'b0, 1'b1, 32'h0000_ABCD, 32'd0, 0, got, lat, stalls);
        checks++;
        if (got !== 32'h0000_ABCD) begin failures++; $display("FAIL rst_pre_result: got %h expected 0000abcd", got); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (bus.stall_req_o !== 1'b0) begin failures++; $display("FAIL rst_stall: got %b expected 0", bus.stall_req_o); end
        @(posedge clk);
        #1;
        checks++;
        if (bus.result_o !== 32'd0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_done: result %h ready %b busy %b expected 0 0 0", bus.result_o, bus.ready_o, bus.busy_o);
        end
        @(negedge clk);
        bus.start_i = 1'b0;
        rst         = 1'b0;
        @(negedge clk);
        bus.start_i = 1'b1;
        bus.op1_i   = 32'd1000;
        bus.op2_i   = 32'd9;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (bus.busy_o !== 1'b1) begin failures++; $display("FAIL rst_busy_before: got %b expected 1", bus.busy_o); end
        @(negedge clk);
        rst         = 1'b1;
        bus.start_i = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (bus.result_o !== 32'd0 || bus.ready_o !== 1'b0 || bus.busy_o !== 1'b0) begin
            failures++;
            $display("FAIL rst_busy: result %h ready %b busy %b expected 0 0 0", bus.result_o, bus.ready_o, bus.busy_o);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_op_change();
        logic [31:0] a, b, got;
        int          lat, stalls;
        for (int i = 0; i < 4; i++) begin
            a = $urandom;
            b = $urandom_range(1, 100000);
            if (i[0]) b = -b;
            run_div(1'b1, i[1], a, b, 3 + 7 * i, got, lat, stalls);
            checks++;
            if (got !== model_div(1'b1, i[1], a, b)) begin
                failures++;
                $display("FAIL op_change%0d: got %h expected %h", i, got, model_div(1'b1, i[1], a, b));
            end
            end_div();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_annul();
        test_rst_mid();
        test_op_change();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
